// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: synchronize, deglitch ps2_clk, deframe scan codes
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] ps2_kbd_code_o,
    output logic       ps2_kbd_strobe_o,
    output logic       ps2_kbd_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_lvl, filt_lvl_q;
    logic [FW-1:0] filt_cnt;
    logic          sample_ev;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_bit, par_n;
    logic [TW-1:0] idle_cnt, idle_cnt_n;
    logic [7:0]    code, code_n;
    logic          strobe, strobe_n;
    logic          err, err_n;
    logic          timeout;

    // Filtered level starts high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_s1     <= 1'b0;
            clk_s2     <= 1'b0;
            dat_s1     <= 1'b0;
            dat_s2     <= 1'b0;
            filt_lvl   <= 1'b1;
            filt_lvl_q <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= ps2_clk_i;
            clk_s2     <= clk_s1;
            dat_s1     <= ps2_data_i;
            dat_s2     <= dat_s1;
            filt_lvl_q <= filt_lvl;
            if (clk_s2 == filt_lvl) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_lvl <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign sample_ev = filt_lvl_q & ~filt_lvl;
    assign timeout   = (state != IDLE) && (idle_cnt == TO_MAX);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            idle_cnt <= '0;
            code     <= '0;
            strobe   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            par_bit  <= par_n;
            idle_cnt <= idle_cnt_n;
            code     <= code_n;
            strobe   <= strobe_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par_bit;
        code_n     = code;
        strobe_n   = 1'b0;
        err_n      = 1'b0;
        idle_cnt_n = idle_cnt;
        if (sample_ev) begin
            idle_cnt_n = '0;
        end else if (state != IDLE && idle_cnt != TO_MAX) begin
            idle_cnt_n = idle_cnt + 1'b1;
        end

        // A timeout wins over a coincident sample, which is dropped.
        if (timeout) begin
            state_n    = IDLE;
            err_n      = 1'b1;
            idle_cnt_n = '0;
        end else if (sample_ev) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        bit_cnt_n = '0;
                        state_n   = DATA;
                    end
                end
                DATA: begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (dat_s2 && (^{shreg, par_bit})) begin
                        code_n   = shreg;
                        strobe_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign ps2_kbd_code_o   = code;
    assign ps2_kbd_strobe_o = strobe;
    assign ps2_kbd_err_o    = err;

endmodule
